// File: rtl/dbg_mem_arbiter_pkg.sv
// Shared types and constants for the debug-module system-bus arbiter.
// Holds the arbiter FSM encoding and the default response timeout.
package dbg_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned DBG_ARB_TIMEOUT = 255;

    // Index width that stays legal (>= 1 bit) for a single requester
    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbg_mem_arbiter_if.sv
// Requester-side and downstream-adapter-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dbg_mem_arbiter_if #(
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [NR_REQ-1:0]                     req_i;
    logic [NR_REQ-1:0]                     we_i;
    logic [NR_REQ-1:0][ADDR_WIDTH-1:0]     addr_i;
    logic [NR_REQ-1:0][DATA_WIDTH-1:0]     wdata_i;
    logic [NR_REQ-1:0][DATA_WIDTH/8-1:0]   be_i;
    logic [NR_REQ-1:0]                     gnt_o;
    logic [NR_REQ-1:0]                     r_valid_o;
    logic [DATA_WIDTH-1:0]                 r_rdata_o;
    logic                                  r_err_o;

    logic                                  mst_req_o;
    logic                                  mst_we_o;
    logic [ADDR_WIDTH-1:0]                 mst_addr_o;
    logic [DATA_WIDTH-1:0]                 mst_wdata_o;
    logic [DATA_WIDTH/8-1:0]               mst_be_o;
    logic                                  mst_gnt_i;
    logic                                  mst_r_valid_i;
    logic [DATA_WIDTH-1:0]                 mst_r_rdata_i;
    logic                                  mst_r_err_i;

    logic                                  busy_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_err_o,
        output mst_req_o, mst_we_o, mst_addr_o, mst_wdata_o, mst_be_o,
        input  mst_gnt_i, mst_r_valid_i, mst_r_rdata_i, mst_r_err_i,
        output busy_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_err_o,
        input  mst_req_o, mst_we_o, mst_addr_o, mst_wdata_o, mst_be_o,
        output mst_gnt_i, mst_r_valid_i, mst_r_rdata_i, mst_r_err_i,
        input  busy_o
    );
endinterface

// File: rtl/dbg_mem_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping around, returned both one-hot and as an index.
module rr_arb_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_oh,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);
    always_comb begin
        o_oh  = '0;
        o_idx = '0;
        o_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned j;
            j = int'(i_ptr) + i;
            // Pointer is always < N, so one wrap step is enough
            if (j >= N) j = j - N;
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_oh[j]  = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/dbg_mem_arbiter.sv
// Single-outstanding round-robin arbiter between the debug module system
// bus requesters and the downstream adapter req/gnt/valid port.
module dbg_mem_arbiter
    import dbg_mem_arbiter_pkg::*;
#(
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = DBG_ARB_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dbg_mem_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = arb_idx_width(NR_REQ);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = 16;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_idx;
    logic [NR_REQ-1:0]       r_oh;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [BE_W-1:0]         r_be;
    logic [CNT_W-1:0]        r_cnt;

    logic [NR_REQ-1:0]       w_pick_oh;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_vld;
    logic                    w_load;
    logic                    w_gnt_fire;
    logic                    w_rsp_fire;
    logic                    w_timeout;

    rr_arb_pick #(
        .N     (NR_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (bus.req_i),
        .i_ptr (r_ptr),
        .o_oh  (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_gnt_fire  = 1'b0;
        w_rsp_fire  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mst_gnt_i) begin
                    w_gnt_fire = 1'b1;
                    // A response in the grant cycle completes the whole transaction
                    if (bus.mst_r_valid_i) begin
                        w_rsp_fire  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.mst_r_valid_i) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_rsp_fire  = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_oh    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_idx   <= w_pick_idx;
                r_oh    <= w_pick_oh;
                r_we    <= bus.we_i[w_pick_idx];
                r_addr  <= bus.addr_i[w_pick_idx];
                r_wdata <= bus.wdata_i[w_pick_idx];
                r_be    <= bus.be_i[w_pick_idx];
            end
            if (w_gnt_fire) begin
                r_ptr <= (r_idx == IDX_W'(NR_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            // Counter reads 0 in the first RESP cycle and advances while waiting
            r_cnt <= (r_state == ST_RESP && w_state_nxt == ST_RESP) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    assign bus.gnt_o       = w_gnt_fire ? r_oh : '0;
    assign bus.r_valid_o   = w_rsp_fire ? r_oh : '0;
    assign bus.r_rdata_o   = (w_rsp_fire && !w_timeout) ? bus.mst_r_rdata_i : '0;
    assign bus.r_err_o     = w_timeout | (w_rsp_fire & bus.mst_r_err_i);

    assign bus.mst_req_o   = (r_state == ST_REQ);
    assign bus.mst_we_o    = r_we;
    assign bus.mst_addr_o  = r_addr;
    assign bus.mst_wdata_o = r_wdata;
    assign bus.mst_be_o    = r_be;
    assign bus.busy_o      = (r_state != ST_IDLE);
endmodule
